// File: rtl/ysyx_22041071_div_ctrl_pkg.sv
// ysyx_22041071_div_ctrl_pkg: shared encodings and helpers for the divide controller
package ysyx_22041071_div_ctrl_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_WAIT = 2'b01, ST_RESP = 2'b10, ST_DRAIN = 2'b11} state_e;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction
endpackage

// File: rtl/ysyx_22041071_div_ctrl_if.sv
// ysyx_22041071_div_ctrl_if: issue, result and divider signals of the divide controller
interface ysyx_22041071_div_ctrl_if #(parameter int TAG_W = 5);
  import ysyx_22041071_div_ctrl_pkg::*;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic             req_w;
  logic [XLEN-1:0]  req_src1;
  logic [XLEN-1:0]  req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy;
  logic             div_valid;
  logic             div_signed;
  logic             divw;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_flush;
  logic             div_ready;
  logic             div_out_valid;
  logic [XLEN-1:0]  div_quot;
  logic [XLEN-1:0]  div_rema;
  modport slave (
    input  flush, req_valid, req_op, req_w, req_src1, req_src2, req_tag, res_ready,
           div_ready, div_out_valid, div_quot, div_rema,
    output req_ready, res_valid, res_data, res_tag, busy, div_valid, div_signed, divw,
           div_dividend, div_divisor, div_flush
  );
  modport master (
    output flush, req_valid, req_op, req_w, req_src1, req_src2, req_tag, res_ready,
           div_ready, div_out_valid, div_quot, div_rema,
    input  req_ready, res_valid, res_data, res_tag, busy, div_valid, div_signed, divw,
           div_dividend, div_divisor, div_flush
  );
endinterface

// File: rtl/ysyx_22041071_div_ctrl_special.sv
// ysyx_22041071_div_special: detects divide-by-zero and signed overflow and forms their RISC-V results
module ysyx_22041071_div_special
  import ysyx_22041071_div_ctrl_pkg::*;
(
  input  logic [1:0]      op_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] res_o
);
  logic            zero;
  logic            ovf;
  logic [XLEN-1:0] src1_x;
  assign src1_x = w_i ? sext32(src1_i[31:0]) : src1_i;
  assign zero = w_i ? (src2_i[31:0] == '0) : (src2_i == '0);
  assign ovf = op_is_signed(op_i) && (w_i ? (src1_i[31:0] == 32'h8000_0000 && src2_i[31:0] == '1)
                                          : (src1_i == {1'b1, {(XLEN-1){1'b0}}} && src2_i == '1));
  assign is_special_o = zero || ovf;
  assign res_o = zero ? (op_is_rem(op_i) ? src1_x : '1) : (op_is_rem(op_i) ? '0 : src1_x);
endmodule

// File: rtl/ysyx_22041071_div_ctrl.sv
// ysyx_22041071_div_ctrl: sequences one divide request through the fast path or the iterative divider
module ysyx_22041071_div_ctrl
  import ysyx_22041071_div_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic                          clk,
  input logic                          reset,
  ysyx_22041071_div_ctrl_if.slave      bus
);
  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic             w_q;
  logic [XLEN-1:0]  src1_q, src2_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             is_special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  div_sel;
  ysyx_22041071_div_special u_special (
    .op_i        (bus.req_op),
    .w_i         (bus.req_w),
    .src1_i      (bus.req_src1),
    .src2_i      (bus.req_src2),
    .is_special_o(is_special),
    .res_o       (special_res)
  );
  assign accept = bus.req_valid && bus.req_ready;
  assign div_sel = op_is_rem(op_q) ? bus.div_rema : bus.div_quot;
  assign bus.req_ready = (state_q == ST_IDLE) && !bus.flush;
  assign bus.res_valid = (state_q == ST_RESP) && !bus.flush;
  assign bus.res_data = res_q;
  assign bus.res_tag = tag_q;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.div_valid = state_q == ST_WAIT;
  assign bus.div_flush = (state_q == ST_DRAIN) || bus.flush;
  assign bus.div_signed = ~op_q[0];
  assign bus.divw = w_q;
  assign bus.div_dividend = src1_q;
  assign bus.div_divisor = src2_q;
  // next state: flush wins everywhere except DRAIN, which only waits for the divider to go idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = accept ? (is_special ? ST_RESP : ST_WAIT) : ST_IDLE;
      ST_WAIT:  state_d = bus.flush ? (bus.div_out_valid ? ST_IDLE : ST_DRAIN)
                                    : (bus.div_out_valid ? ST_RESP : ST_WAIT);
      ST_RESP:  state_d = (bus.flush || bus.res_ready) ? ST_IDLE : ST_RESP;
      ST_DRAIN: state_d = bus.div_ready ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end
  // state, latched request and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      w_q     <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.req_op;
        w_q    <= bus.req_w;
        src1_q <= bus.req_src1;
        src2_q <= bus.req_src2;
        tag_q  <= bus.req_tag;
        res_q  <= special_res;
      end
      if (state_q == ST_WAIT && bus.div_out_valid && !bus.flush)
        res_q <= w_q ? sext32(div_sel[31:0]) : div_sel;
    end
  end
endmodule

// File: doc/ysyx_22041071_div_ctrl.md
Name: ysyx_22041071_div_ctrl

Overview:
Sequencing controller between the EXU M-extension issue point and the iterative 64-bit divider. Accepts one DIV/DIVU/REM/REMU request (64-bit or W form) through a valid/ready handshake. Resolves RISC-V divide-by-zero and signed-overflow cases locally in one cycle; all other requests go to the divider, with operands held stable until it reports done. Returns the selected, W-sign-extended result with its tag through a valid/ready handshake, and handles pipeline flush, including draining an in-flight division.

Parameters:
XLEN, 64, datapath width; must match the divider.
TAG_W, 5, width of the opaque request tag (destination register index).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  cancel the current request and any pending result.
req_valid  in  1  request present.
req_ready  out  1  controller accepts a request; equals (state==IDLE && !flush).
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
req_w  in  1  W form (32-bit operation, sign-extended result).
req_src1  in  XLEN  dividend.
req_src2  in  XLEN  divisor.
req_tag  in  TAG_W  tag; returned unchanged with the result.
res_valid  out  1  result present.
res_ready  in  1  consumer takes the result.
res_data  out  XLEN  result.
res_tag  out  TAG_W  tag of the result.
busy  out  1  state != IDLE.
div_valid  out  1  to divider; level request, held from launch until div_out_valid.
div_signed  out  1  ~req_op[0] of the latched request.
divw  out  1  latched req_w.
div_dividend  out  XLEN  latched src1.
div_divisor  out  XLEN  latched src2.
div_flush  out  1  to divider flush.
div_ready  in  1  divider is idle.
div_out_valid  in  1  divider result valid (single cycle).
div_quot  in  XLEN  divider quotient.
div_rema  in  XLEN  divider remainder.

Behaviour:
- Reset values: state IDLE; all latched operands and result registers 0; res_valid, div_valid, div_flush, busy all 0. req_ready is 1 whenever reset is low and flush is low.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE, accept on req_valid && req_ready: latch op, w, src1, src2, tag.
  - Divisor zero (src2==0; or src2[31:0]==0 when w=1): go to RESP.
    - DIV/DIVU result: all ones.
    - REM/REMU result: src1, or sext(src1[31:0]) when w=1.
  - Signed overflow (op DIV/REM with src1=0x8000000000000000 and src2=all ones; when w=1, src1[31:0]=0x80000000 and src2[31:0]=0xFFFFFFFF): go to RESP.
    - DIV result: src1, or 0xFFFFFFFF80000000 when w=1.
    - REM result: 0.
  - Otherwise go to WAIT. div_valid is asserted from the next cycle.
- WAIT: div_valid=1 with operands stable. On div_out_valid, capture div_quot (DIV/DIVU) or div_rema (REM/REMU) into res_data and go to RESP. For w=1, res_data = sext(selected[31:0]). div_valid drops the following cycle, so the divider returns to idle without relaunching.
- RESP: res_valid=1. res_data and res_tag hold until res_ready; on res_ready go to IDLE. A new request can be accepted on the following cycle, not the same cycle.
- Latency: fast path gives res_valid 1 cycle after accept. The divider path gives res_valid 1 cycle after div_out_valid.
- Flush priority is highest in every state:
  - IDLE: no accept.
  - RESP: result discarded, go to IDLE.
  - WAIT with div_out_valid in the same cycle: result discarded, go to IDLE.
  - WAIT otherwise: go to DRAIN.
- DRAIN: div_valid=0, div_flush=1. Go to IDLE on the first cycle with div_ready=1; further flush pulses are ignored. div_flush is also asserted combinationally in any cycle where flush=1.
- res_valid is never asserted in the same cycle as flush.

Decomposition:
- Shared define file holds:
  - the req_op encodings (DIV/DIVU/REM/REMU);
  - the state encodings (IDLE=00, WAIT=01, RESP=10, DRAIN=11);
  - XLEN.
- One natural sub-module, ysyx_22041071_div_special. It is purely combinational: from op, w, src1 and src2 it computes is_special and the special-case result. The FSM and result register stay in the top module.

Test Plan:
- DIV, w=0, src1=-20 (0xFFFFFFFFFFFFFFEC), src2=3 -> divider launched, div_signed=1. Result 0xFFFFFFFFFFFFFFFA (-6), tag preserved; REM on the same operands gives 0xFFFFFFFFFFFFFFFE (-2).
- DIVUW, src1=0x00000000FFFFFFFF, src2=0x0000000000000001 -> 32-bit quotient 0xFFFFFFFF, res_data 0xFFFFFFFFFFFFFFFF (sign-extended).
- REMU, src2=0, src1=0x1234 -> res_valid the next cycle with 0x1234; div_valid never asserted. DIVW with src2[31:0]=0 gives 0xFFFFFFFFFFFFFFFF.
- DIVW, src1=0x0000000080000000, src2=0x00000000FFFFFFFF -> fast path, 0xFFFFFFFF80000000. REMW on the same operands gives 0.
- Flush 10 cycles after a DIVU launch -> DRAIN with div_flush=1 until div_ready, no res_valid, req_ready=0 until IDLE. A following request then completes correctly.
- Hold res_ready low for 5 cycles in RESP -> res_data and res_tag stable and req_ready=0. Flush asserted in the same cycle as div_out_valid -> IDLE next cycle, no result.
